// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw against a
// word-addressed data memory, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int DMEM_WORDS = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [1:0]         size,
  input  logic               load_unsigned,
  output logic               busy,
  output logic               done,
  output logic [31:0]        load_data,
  output logic               misalign,
  output logic               range_err,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_write_data,
  output logic               dmem_memwrite,
  output logic               dmem_memread,
  input  logic [31:0]        dmem_read_data,
  output logic [2:0]         state_dbg
);

  // Handshake: req is taken only in IDLE (busy=0); busy stays high until the
  // cycle after the single done pulse, and any req seen while busy is dropped.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DMEM_WORDS);

  state_t state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               misalign_q, misalign_d;
  logic               range_err_q, range_err_d;
  logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               memwrite_q, memwrite_d;
  logic               memread_q, memread_d;
  logic [1:0]         lo_q, lo_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [15:0]        wdata_q, wdata_d;

  logic acc_mis, acc_oor;

  function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extract_lane = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   extract_lane = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: extract_lane = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [15:0] d,
                                             input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) begin
      case (lo)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end else if (lo[1]) begin
      m[31:16] = d;
    end else begin
      m[15:0] = d;
    end
    merge_lane = m;
  endfunction

  always_comb begin
    acc_mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    acc_oor = (addr >= ADDR_LIMIT);
  end

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    load_data_d = load_data_q;
    misalign_d  = misalign_q;
    range_err_d = range_err_q;
    dmem_addr_d = dmem_addr_q;
    wr_data_d   = wr_data_q;
    lo_d        = lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          lo_d        = addr[1:0];
          size_d      = size;
          uns_d       = load_unsigned;
          wdata_d     = wdata[15:0];
          dmem_addr_d = addr[DMEM_AW+1:2];
          if (!memread && !memwrite) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            misalign_d  = 1'b0;
            range_err_d = 1'b0;
          end else if (acc_mis || acc_oor) begin
            // Misalignment masks the range error.
            state_d     = S_DONE;
            done_d      = 1'b1;
            misalign_d  = acc_mis;
            range_err_d = !acc_mis;
          end else if (memwrite && size[1]) begin
            state_d    = S_WR;
            memwrite_d = 1'b1;
            wr_data_d  = wdata;
          end else if (memwrite) begin
            state_d   = S_RMW_RD;
            memread_d = 1'b1;
          end else begin
            state_d   = S_RD;
            memread_d = 1'b1;
          end
        end
      end
      S_RD: begin
        load_data_d = extract_lane(dmem_read_data, lo_q, size_q, uns_q);
        state_d     = S_DONE;
        done_d      = 1'b1;
        misalign_d  = 1'b0;
        range_err_d = 1'b0;
      end
      S_RMW_RD: begin
        wr_data_d  = merge_lane(dmem_read_data, wdata_q, lo_q, size_q);
        memwrite_d = 1'b1;
        state_d    = S_RMW_WR;
      end
      S_WR, S_RMW_WR: begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        misalign_d  = 1'b0;
        range_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
      range_err_q <= 1'b0;
      dmem_addr_q <= '0;
      wr_data_q   <= '0;
      memwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      lo_q        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
      range_err_q <= range_err_d;
      dmem_addr_q <= dmem_addr_d;
      wr_data_q   <= wr_data_d;
      memwrite_q  <= memwrite_d;
      memread_q   <= memread_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign load_data       = load_data_q;
  assign misalign        = misalign_q;
  assign range_err       = range_err_q;
  assign dmem_addr       = dmem_addr_q;
  assign dmem_write_data = wr_data_q;
  assign dmem_memwrite   = memwrite_q;
  assign dmem_memread    = memread_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory and
// hand-computed expected results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [1:0]  size = '0;
  logic        load_unsigned = 1'b0;
  logic        busy, done, misalign, range_err;
  logic [31:0] load_data, dmem_write_data, dmem_read_data;
  logic [7:0]  dmem_addr;
  logic        dmem_memwrite, dmem_memread;
  logic [2:0]  state_dbg;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  int          r_lat, r_ndone, r_nwr, r_nrd;
  logic        r_both, r_mis, r_rng;
  logic [31:0] r_ld;
  logic [7:0]  r_addr;

  mem_access_unit #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .memread(memread), .memwrite(memwrite), .size(size), .load_unsigned(load_unsigned),
    .busy(busy), .done(done), .load_data(load_data), .misalign(misalign),
    .range_err(range_err), .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_memwrite(dmem_memwrite), .dmem_memread(dmem_memread),
    .dmem_read_data(dmem_read_data), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  assign dmem_read_data = mem[dmem_addr];
  always @(posedge clk) if (dmem_memwrite) mem[dmem_addr] <= dmem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and watches 8 cycles; optionally pokes a second req while busy.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic poke);
    r_lat = -1; r_ndone = 0; r_nwr = 0; r_nrd = 0;
    r_both = 1'b0; r_mis = 1'b0; r_rng = 1'b0; r_ld = '0; r_addr = '0;
    @(negedge clk);
    req = 1'b1; memread = rd; memwrite = wr; size = sz; load_unsigned = uns;
    addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (poke && c == 1) begin
        req = 1'b1; memread = 1'b0; memwrite = 1'b1; size = 2'b10;
        addr = 32'h28; wdata = 32'h1111_1111;
      end
      if (poke && c == 3) req = 1'b0;
      if (dmem_memwrite) r_nwr++;
      if (dmem_memread) r_nrd++;
      if (dmem_memwrite && dmem_memread) r_both = 1'b1;
      if (dmem_memwrite || dmem_memread) r_addr = dmem_addr;
      if (done) begin
        r_ndone++;
        if (r_lat < 0) begin
          r_lat = c; r_mis = misalign; r_rng = range_err; r_ld = load_data;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 32'({busy, done, misalign, range_err, dmem_memwrite, dmem_memread}), 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_dmem_addr", 32'(dmem_addr), 32'h0);
    check("rst_wdata", dmem_write_data, 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;

    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0);
    check("sw_lat", r_lat, 2);
    check("sw_nwr", r_nwr, 1);
    check("sw_nrd", r_nrd, 0);
    check("sw_addr", 32'(r_addr), 8);
    check("sw_mem", mem[8], 32'hDEAD_BEEF);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    check("lw_lat", r_lat, 2);
    check("lw_data", r_ld, 32'hDEAD_BEEF);
    check("lw_nrd", r_nrd, 1);
    check("lw_flags", 32'({r_mis, r_rng}), 0);

    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h7F5A, 1'b0);
    check("sb_lat", r_lat, 3);
    check("sb_nwr", r_nwr, 1);
    check("sb_nrd", r_nrd, 1);
    check("sb_both", 32'(r_both), 0);
    check("sb_mem", mem[8], 32'hDEAD_5AEF);

    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0);
    check("lb21", r_ld, 32'h0000_005A);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0);
    check("lb23", r_ld, 32'hFFFF_FFDE);
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0);
    check("lbu23", r_ld, 32'h0000_00DE);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0);
    check("lh22", r_ld, 32'hFFFF_DEAD);
    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0);
    check("lhu22", r_ld, 32'h0000_DEAD);

    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, 1'b0);
    check("sh_lat", r_lat, 3);
    check("sh_mem", mem[8], 32'h1234_5AEF);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0);
    check("lw_mis_lat", r_lat, 1);
    check("lw_mis_flags", 32'({r_mis, r_rng}), 32'h2);
    check("lw_mis_strobes", r_nrd + r_nwr, 0);
    check("lw_mis_ld_held", r_ld, 32'h0000_DEAD);

    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 1'b0);
    check("lh401_flags", 32'({r_mis, r_rng}), 32'h2);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0);
    check("lw400_lat", r_lat, 1);
    check("lw400_flags", 32'({r_mis, r_rng}), 32'h1);
    check("lw400_strobes", r_nrd + r_nwr, 0);

    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0);
    check("noop_lat", r_lat, 1);
    check("noop_flags", 32'({r_mis, r_rng}), 0);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    check("lw_after_fault_flags", 32'({r_mis, r_rng}), 0);
    check("lw_after_fault_data", r_ld, 32'h1234_5AEF);

    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFE_F00D, 1'b1);
    check("busy_ndone", r_ndone, 1);
    check("busy_nwr", r_nwr, 1);
    check("busy_mem9", mem[9], 32'hCAFE_F00D);
    check("busy_mem10", mem[10], 32'h0);

    @(negedge clk);
    req = 1'b1; memread = 1'b0; memwrite = 1'b1; size = 2'b00;
    addr = 32'h20; wdata = 32'h0000_00AB;
    @(posedge clk);
    #1 req = 1'b0;
    check("rmw_rd_state", 32'(state_dbg), 32'h3);
    check("rmw_rd_strobe", 32'(dmem_memread), 1);
    rst = 1'b1;
    #1;
    check("midrst_ctl", 32'({busy, done, misalign, range_err, dmem_memwrite, dmem_memread}), 32'h0);
    check("midrst_load_data", load_data, 32'h0);
    check("midrst_dmem_addr", 32'(dmem_addr), 32'h0);
    check("midrst_state", 32'(state_dbg), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_mem8", mem[8], 32'h1234_5AEF);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    check("post_rst_lat", r_lat, 2);
    check("post_rst_data", r_ld, 32'h1234_5AEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
